// File: rtl/ysyx_23060208_pc_sequencer_if.sv
// Fetch-side bus of the PC sequencer: IMEM request/response and the
// instruction handoff to the IDU.
interface ysyx_23060208_pc_sequencer_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [DATA_WIDTH-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic [31:0]           imem_rsp_data;
  logic                  imem_rsp_err;
  logic                  inst_valid;
  logic                  inst_ready;
  logic [31:0]           inst;
  logic [DATA_WIDTH-1:0] inst_pc;

  modport master (
    output imem_req_valid,
    input  imem_req_ready,
    output imem_req_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_err,
    output inst_valid,
    input  inst_ready,
    output inst,
    output inst_pc
  );

  modport slave (
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_req_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output imem_rsp_err,
    input  inst_valid,
    output inst_ready,
    input  inst,
    input  inst_pc
  );
endinterface

// File: rtl/ysyx_23060208_pc_sequencer.sv
// Multicycle fetch/PC controller: steps the PC out of reset, fetches one
// instruction at a time, hands it to the IDU and selects the next PC on commit.
module ysyx_23060208_pc_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pc,
  output logic                  pc_wen,
  output logic [DATA_WIDTH-1:0] next_pc,
  ysyx_23060208_pc_sequencer_if.master bus,
  input  logic                  commit_valid,
  input  logic                  trap_valid,
  input  logic [DATA_WIDTH-1:0] trap_target,
  input  logic                  mret_valid,
  input  logic [DATA_WIDTH-1:0] mret_target,
  input  logic                  br_taken,
  input  logic [DATA_WIDTH-1:0] br_target,
  output logic                  fetch_fault,
  output logic                  busy
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]         TMO_LAST   = CW'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = {{(DATA_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [DATA_WIDTH-1:0] PC_STEP    = DATA_WIDTH'(4);

  typedef enum logic [2:0] {
    S_STEP,
    S_REQ,
    S_WAIT,
    S_ISSUE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t                state, state_nxt;
  logic [CW-1:0]         tmo_cnt;
  logic [31:0]           inst_q;
  logic [DATA_WIDTH-1:0] inst_pc_q;

  logic                  pc_wen_c;
  logic [DATA_WIDTH-1:0] next_pc_c;
  logic                  req_valid_c;
  logic                  inst_valid_c;
  logic                  rsp_ok;

  assign rsp_ok = bus.imem_rsp_valid & ~bus.imem_rsp_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_STEP;
      tmo_cnt   <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      state <= state_nxt;
      // Counter is held at zero while requesting so WAIT always starts fresh.
      if (state == S_REQ) begin
        tmo_cnt <= '0;
      end else if (state == S_WAIT) begin
        tmo_cnt <= tmo_cnt + CW'(1);
      end
      if (state == S_WAIT && rsp_ok) begin
        inst_q    <= bus.imem_rsp_data;
        inst_pc_q <= pc;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_wen_c     = 1'b0;
    next_pc_c    = '0;
    req_valid_c  = 1'b0;
    inst_valid_c = 1'b0;
    case (state)
      S_STEP: begin
        pc_wen_c  = 1'b1;
        next_pc_c = pc + PC_STEP;
        state_nxt = S_REQ;
      end
      S_REQ: begin
        req_valid_c = 1'b1;
        if (bus.imem_req_ready) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          state_nxt = bus.imem_rsp_err ? S_HALT : S_ISSUE;
        end else if (tmo_cnt == TMO_LAST) begin
          state_nxt = S_HALT;
        end
      end
      S_ISSUE: begin
        inst_valid_c = 1'b1;
        if (bus.inst_ready) state_nxt = S_EXEC;
      end
      S_EXEC: begin
        if (commit_valid) begin
          pc_wen_c  = 1'b1;
          state_nxt = S_REQ;
          if (trap_valid) begin
            next_pc_c = trap_target & ALIGN_MASK;
          end else if (mret_valid) begin
            next_pc_c = mret_target & ALIGN_MASK;
          end else if (br_taken) begin
            next_pc_c = br_target & ALIGN_MASK;
          end else begin
            next_pc_c = pc + PC_STEP;
          end
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_STEP;
      end
    endcase
  end

  // Every output is forced low while rst is held, independent of state.
  assign pc_wen             = pc_wen_c & ~rst;
  assign next_pc            = rst ? '0 : next_pc_c;
  assign bus.imem_req_valid = req_valid_c & ~rst;
  assign bus.imem_req_addr  = rst ? '0 : pc;
  assign bus.inst_valid     = inst_valid_c & ~rst;
  assign bus.inst           = rst ? '0 : inst_q;
  assign bus.inst_pc        = rst ? '0 : inst_pc_q;
  assign fetch_fault        = ~rst & (state == S_HALT);
  assign busy               = ~rst & (state != S_HALT);

endmodule

// File: tb/tb_ysyx_23060208_pc_sequencer.sv
// Directed bench for the PC sequencer: external PC register model, scoreboard
// queues for fetches, instruction handoffs and PC writes.
module tb_ysyx_23060208_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_wen;
  logic [31:0] next_pc;
  logic        commit_valid;
  logic        trap_valid, mret_valid, br_taken;
  logic [31:0] trap_target, mret_target, br_target;
  logic        fetch_fault, busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int fetch_cnt = 0;

  logic [31:0] q_fetch[$];
  logic [63:0] q_inst[$];
  logic [31:0] q_pc[$];
  int          hs_cyc[$];

  ysyx_23060208_pc_sequencer_if #(.DATA_WIDTH(32)) bus ();

  ysyx_23060208_pc_sequencer #(
    .DATA_WIDTH(32),
    .TIMEOUT   (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .pc_wen      (pc_wen),
    .next_pc     (next_pc),
    .bus         (bus.master),
    .commit_valid(commit_valid),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .mret_valid  (mret_valid),
    .mret_target (mret_target),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .fetch_fault (fetch_fault),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // PC register the sequencer drives.
  always @(posedge clk) begin
    if (rst) pc <= 32'h2FFF_FFFC;
    else if (pc_wen) pc <= next_pc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        fetch_cnt++;
        hs_cyc.push_back(cyc);
        chk("fetch_pending", 64'(q_fetch.size() != 0), 64'd1);
        if (q_fetch.size() != 0) chk("fetch_addr", 64'(bus.imem_req_addr), 64'(q_fetch.pop_front()));
      end
      if (bus.inst_valid && bus.inst_ready) begin
        chk("inst_pending", 64'(q_inst.size() != 0), 64'd1);
        if (q_inst.size() != 0) chk("inst_word_pc", {bus.inst, bus.inst_pc}, q_inst.pop_front());
      end
      if (pc_wen) begin
        chk("pcwen_pending", 64'(q_pc.size() != 0), 64'd1);
        if (q_pc.size() != 0) chk("next_pc", 64'(next_pc), 64'(q_pc.pop_front()));
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Starts in a REQ cycle and returns at the start of the following REQ cycle.
  task automatic do_instr(input logic [31:0] addr, input logic [31:0] word,
                          input int unsigned req_stall, input int unsigned iss_stall,
                          input int unsigned exec_stall,
                          input logic tv, input logic mv, input logic bv,
                          input logic [31:0] exp_next);
    for (int unsigned i = 0; i < req_stall; i++) begin
      bus.imem_req_ready = 1'b0;
      @(negedge clk);
      chk("req_hold_valid", 64'(bus.imem_req_valid), 64'd1);
      chk("req_hold_addr", 64'(bus.imem_req_addr), 64'(addr));
      chk("req_hold_nowen", 64'(pc_wen), 64'd0);
      nxt();
    end
    bus.imem_req_ready = 1'b1;
    q_fetch.push_back(addr);
    @(negedge clk);
    chk("req_valid", 64'(bus.imem_req_valid), 64'd1);
    chk("req_addr", 64'(bus.imem_req_addr), 64'(addr));
    nxt();
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data  = word;
    bus.imem_rsp_err   = 1'b0;
    q_inst.push_back({word, addr});
    @(negedge clk);
    chk("wait_no_issue", 64'(bus.inst_valid), 64'd0);
    nxt();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = $urandom;
    for (int unsigned i = 0; i < iss_stall; i++) begin
      bus.inst_ready = 1'b0;
      @(negedge clk);
      chk("iss_hold_valid", 64'(bus.inst_valid), 64'd1);
      chk("iss_hold_inst", 64'(bus.inst), 64'(word));
      chk("iss_hold_pc", 64'(bus.inst_pc), 64'(addr));
      chk("iss_hold_nowen", 64'(pc_wen), 64'd0);
      nxt();
    end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    chk("iss_valid", 64'(bus.inst_valid), 64'd1);
    nxt();
    bus.inst_ready = 1'b0;
    for (int unsigned i = 0; i < exec_stall; i++) begin
      trap_valid = 1'b1;
      mret_valid = 1'b1;
      br_taken   = 1'b1;
      @(negedge clk);
      chk("exec_nocommit_nowen", 64'(pc_wen), 64'd0);
      chk("exec_noreq", 64'(bus.imem_req_valid), 64'd0);
      nxt();
    end
    commit_valid = 1'b1;
    trap_valid   = tv;
    mret_valid   = mv;
    br_taken     = bv;
    q_pc.push_back(exp_next);
    @(negedge clk);
    chk("commit_wen", 64'(pc_wen), 64'd1);
    nxt();
    commit_valid = 1'b0;
    trap_valid   = 1'b0;
    mret_valid   = 1'b0;
    br_taken     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int f0;
    rst = 1'b1;
    commit_valid = 1'b0;
    trap_valid = 1'b0;
    mret_valid = 1'b0;
    br_taken = 1'b0;
    trap_target = 32'h3000_0200;
    mret_target = 32'h3000_0302;
    br_target = 32'h3000_0101;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data = 32'hDEAD_BEEF;
    bus.imem_rsp_err = 1'b0;
    bus.inst_ready = 1'b0;
    nxt();

    @(negedge clk);
    chk("rst_pc_wen", 64'(pc_wen), 64'd0);
    chk("rst_next_pc", 64'(next_pc), 64'd0);
    chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
    chk("rst_req_addr", 64'(bus.imem_req_addr), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
    chk("rst_inst", 64'(bus.inst), 64'd0);
    chk("rst_inst_pc", 64'(bus.inst_pc), 64'd0);
    chk("rst_fault", 64'(fetch_fault), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    nxt();

    // Boot step: cycle 0
    rst = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    q_pc.push_back(32'h3000_0000);
    @(negedge clk);
    chk("boot_wen", 64'(pc_wen), 64'd1);
    chk("boot_noreq", 64'(bus.imem_req_valid), 64'd0);
    chk("boot_busy", 64'(busy), 64'd1);
    nxt();

    // Sequential, then redirect priority
    do_instr(32'h3000_0000, 32'h0000_0013, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h3000_0004);
    do_instr(32'h3000_0004, 32'h0000_0063, 0, 0, 0, 1'b1, 1'b1, 1'b1, 32'h3000_0200);
    chk("seq_spacing", 64'(hs_cyc[1] - hs_cyc[0]), 64'd4);
    do_instr(32'h3000_0200, 32'h0000_006F, 0, 0, 0, 1'b0, 1'b0, 1'b1, 32'h3000_0100);
    do_instr(32'h3000_0100, 32'h3020_0073, 0, 0, 0, 1'b0, 1'b1, 1'b1, 32'h3000_0300);

    // Backpressure on both handshakes plus redirects outside the commit cycle
    f0 = fetch_cnt;
    do_instr(32'h3000_0300, 32'h00A0_0513, 3, 2, 2, 1'b0, 1'b0, 1'b0, 32'h3000_0304);
    chk("bp_one_fetch", 64'(fetch_cnt - f0), 64'd1);

    // Wraparound at the top of the address space
    br_target = 32'hFFFF_FFFF;
    do_instr(32'h3000_0304, 32'h0000_0067, 0, 0, 0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    do_instr(32'hFFFF_FFFC, 32'h0000_0013, 0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);

    // Bus error in WAIT
    bus.imem_req_ready = 1'b1;
    q_fetch.push_back(32'h0000_0000);
    @(negedge clk);
    chk("err_req_addr", 64'(bus.imem_req_addr), 64'd0);
    nxt();
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_err = 1'b1;
    @(negedge clk);
    chk("err_wait_busy", 64'(busy), 64'd1);
    nxt();
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_err = 1'b0;
    commit_valid = 1'b1;
    f0 = fetch_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("halt_fault", 64'(fetch_fault), 64'd1);
      chk("halt_busy", 64'(busy), 64'd0);
      chk("halt_noreq", 64'(bus.imem_req_valid), 64'd0);
      chk("halt_nowen", 64'(pc_wen), 64'd0);
      chk("halt_noissue", 64'(bus.inst_valid), 64'd0);
      nxt();
    end
    chk("halt_no_fetch", 64'(fetch_cnt - f0), 64'd0);
    commit_valid = 1'b0;

    // Leave HALT via reset, then reset again in the middle of WAIT
    rst = 1'b1;
    @(negedge clk);
    chk("rst_from_halt_fault", 64'(fetch_fault), 64'd0);
    nxt();
    rst = 1'b0;
    q_pc.push_back(32'h3000_0000);
    @(negedge clk);
    chk("restart_wen", 64'(pc_wen), 64'd1);
    nxt();
    bus.imem_req_ready = 1'b1;
    q_fetch.push_back(32'h3000_0000);
    @(negedge clk);
    nxt();
    bus.imem_req_ready = 1'b0;
    @(negedge clk);
    chk("midwait_busy", 64'(busy), 64'd1);
    nxt();
    rst = 1'b1;
    bus.imem_rsp_valid = 1'b1;
    bus.imem_rsp_data = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("midrst_wen", 64'(pc_wen), 64'd0);
    chk("midrst_next_pc", 64'(next_pc), 64'd0);
    chk("midrst_req", 64'(bus.imem_req_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    nxt();
    rst = 1'b0;
    q_pc.push_back(32'h3000_0000);
    @(negedge clk);
    chk("stale_step_wen", 64'(pc_wen), 64'd1);
    chk("stale_step_noissue", 64'(bus.inst_valid), 64'd0);
    nxt();
    do_instr(32'h3000_0000, 32'h0010_0093, 1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h3000_0004);

    // Response timeout: 8 WAIT cycles after the handshake, then HALT
    bus.imem_req_ready = 1'b1;
    q_fetch.push_back(32'h3000_0004);
    @(negedge clk);
    nxt();
    bus.imem_req_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("tmo_wait_busy", 64'(busy), 64'd1);
      chk("tmo_wait_nofault", 64'(fetch_fault), 64'd0);
      nxt();
    end
    bus.imem_rsp_valid = 1'b1;
    @(negedge clk);
    chk("tmo_fault", 64'(fetch_fault), 64'd1);
    chk("tmo_busy", 64'(busy), 64'd0);
    nxt();
    bus.imem_rsp_valid = 1'b0;

    @(negedge clk);
    chk("sb_fetch_empty", 64'(q_fetch.size()), 64'd0);
    chk("sb_inst_empty", 64'(q_inst.size()), 64'd0);
    chk("sb_pc_empty", 64'(q_pc.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
